// File: rtl/yin_pkg.sv
// yin_pkg: shared types and sizing helpers for the YIN frame scheduler.
//   state_e  - top-level sequencer states
//   phase_e  - lag-search phases inside the tau picker
//   frame_len/tau_bits - derived widths from the top-level parameters
package yin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SCAN,
    ST_REPORT
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_A,     // looking for the first lag under threshold
    PH_B      // descending to the local minimum after a hit
  } phase_e;

  function automatic int frame_len(input int wsb, input int max_tau);
    return (1 << wsb) + max_tau;
  endfunction

  function automatic int tau_bits(input int max_tau);
    return $clog2(max_tau);
  endfunction

endpackage

// File: rtl/yin_frame_scheduler_if.sv
// yin_frame_scheduler_if: bus between the scheduler and modiff_module.
//   mod_reset   - scheduler -> modiff, holds the datapath in reset
//   mod_data    - scheduler -> modiff, frozen frame (element 0 = oldest)
//   mod_ready   - modiff -> scheduler, results valid
//   mod_results - modiff -> scheduler, d'(k) per lag
interface yin_frame_scheduler_if
  import yin_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_TAU    = 40,
  parameter int FRAME_LEN  = frame_len(8, 40),
  parameter int IDW        = 64
);
  logic                                  mod_reset;
  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0]  mod_data;
  logic                                  mod_ready;
  logic [MAX_TAU-1:0][IDW-1:0]           mod_results;

  modport master (output mod_reset, mod_data, input mod_ready, mod_results);
  modport slave  (input mod_reset, mod_data, output mod_ready, mod_results);
endinterface

// File: rtl/yin_tau_picker.sv
// yin_tau_picker: lag search over d'(tau), one lag per cycle.
//   start     - begin a search at k = MIN_TAU (results must be stable)
//   results   - d'(k) per lag
//   threshold - voicing threshold (unsigned compare)
//   done      - combinational, high in the cycle the decision is made
//   tau/voiced- decision, valid while done is high
module yin_tau_picker
  import yin_pkg::*;
#(
  parameter int MAX_TAU  = 40,
  parameter int MIN_TAU  = 2,
  parameter int IDW      = 64,
  parameter int TAU_BITS = tau_bits(MAX_TAU)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [MAX_TAU-1:0][IDW-1:0]  results,
  input  logic [IDW-1:0]               threshold,
  output logic                         done,
  output logic [TAU_BITS-1:0]          tau,
  output logic                         voiced
);
  localparam logic [TAU_BITS-1:0] K_MIN  = TAU_BITS'(MIN_TAU);
  localparam logic [TAU_BITS-1:0] K_LAST = TAU_BITS'(MAX_TAU - 1);

  phase_e              phase_q;
  logic [TAU_BITS-1:0] k_q, best_k_q;
  logic [IDW-1:0]      best_v_q;

  logic                last, descend, hit, new_best;
  logic [TAU_BITS-1:0] k_nx, best_k_d;
  logic [IDW-1:0]      d_k, d_nx, best_v_d;

  always_comb begin
    last     = (k_q == K_LAST);
    // never index past the table; the neighbour is ignored on the last lag
    k_nx     = last ? k_q : k_q + 1'b1;
    d_k      = results[k_q];
    d_nx     = results[k_nx];
    descend  = !last && (d_nx < d_k);
    // strict compare keeps the lowest lag on ties
    new_best = (k_q == K_MIN) || (d_k < best_v_q);
    best_k_d = new_best ? k_q : best_k_q;
    best_v_d = new_best ? d_k : best_v_q;
    hit      = (phase_q == PH_B) || ((phase_q == PH_A) && (d_k < threshold));
    done     = 1'b0;
    tau      = best_k_d;
    voiced   = 1'b0;
    if (phase_q != PH_IDLE) begin
      if (hit && !descend) begin
        done   = 1'b1;
        tau    = k_q;
        voiced = 1'b1;
      end else if (!hit && last) begin
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      k_q      <= '0;
      best_k_q <= '0;
      best_v_q <= '0;
    end else if (start) begin
      phase_q <= PH_A;
      k_q     <= K_MIN;
    end else if (phase_q != PH_IDLE) begin
      best_k_q <= best_k_d;
      best_v_q <= best_v_d;
      if (done) begin
        phase_q <= PH_IDLE;
      end else begin
        k_q <= k_nx;
        if (hit) phase_q <= PH_B;
      end
    end
  end
endmodule

// File: rtl/yin_frame_scheduler.sv
// yin_frame_scheduler: frames a live sample stream for modiff_module and
// picks the pitch period from its d'(tau) results.
//   clk/reset  - clock, synchronous active-high reset
//   s_valid/s_data - sample stream, accepted whenever s_valid is high
//   threshold  - voicing threshold for d'(tau)
//   mod_if     - modiff_module bus (reset, frozen frame, ready, results)
//   tau_out/voiced/tau_valid - pitch decision, tau_valid pulses once
//   busy       - not IDLE
//   overrun    - pulses when a frame trigger is dropped because busy
// Optional: define YIN_TIMEOUT_EN to add a WAIT watchdog and a timeout pulse.
module yin_frame_scheduler
  import yin_pkg::*;
#(
  parameter int DATA_WIDTH              = 8,
  parameter int WINDOW_SIZE_BITS        = 8,
  parameter int MAX_TAU                 = 40,
  parameter int INTERMEDIATE_DATA_WIDTH = 64,
  parameter int HOP                     = 128,
  parameter int MIN_TAU                 = 2,
  parameter int TIMEOUT_CYCLES          = 65535,
  localparam int FRAME_LEN              = frame_len(WINDOW_SIZE_BITS, MAX_TAU),
  localparam int TAU_BITS               = tau_bits(MAX_TAU)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] threshold,
  yin_frame_scheduler_if.master              mod_if,
  output logic [TAU_BITS-1:0]                tau_out,
  output logic                               voiced,
  output logic                               tau_valid,
  output logic                               busy,
  output logic                               overrun
`ifdef YIN_TIMEOUT_EN
  ,output logic                              timeout
`endif
);
  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(FRAME_LEN);
  localparam logic [HW-1:0] HOP_LAST = HW'(HOP - 1);

  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] frame_q, frame_d, mod_data_q;
  logic [FW-1:0]       fill_q, fill_nx;
  logic [HW-1:0]       hop_q, hop_nx;
  state_e              state_q;
  logic                wait_first_q, mod_reset_q;
  logic [TAU_BITS-1:0] tau_q;
  logic                voiced_q, tau_valid_q, overrun_q;
  logic                trigger, pick_start, pick_done, pick_voiced;
  logic [TAU_BITS-1:0] pick_tau;

  // frame_d already includes the current sample, so it doubles as the snapshot
  assign frame_d    = {s_data, frame_q[FRAME_LEN-1:1]};
  assign fill_nx    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign hop_nx     = (hop_q == HOP_LAST) ? '0 : hop_q + 1'b1;
  assign trigger    = s_valid && (fill_nx == FILL_MAX) && (hop_q == HOP_LAST);
  // first WAIT cycle ignores mod_ready, it may still reflect the previous frame
  assign pick_start = (state_q == ST_WAIT) && !wait_first_q && mod_if.mod_ready;

  yin_tau_picker #(
    .MAX_TAU (MAX_TAU),
    .MIN_TAU (MIN_TAU),
    .IDW     (INTERMEDIATE_DATA_WIDTH),
    .TAU_BITS(TAU_BITS)
  ) u_picker (
    .clk      (clk),
    .reset    (reset),
    .start    (pick_start),
    .results  (mod_if.mod_results),
    .threshold(threshold),
    .done     (pick_done),
    .tau      (pick_tau),
    .voiced   (pick_voiced)
  );

  // frame contents need no reset; fill_q gates their use
  always_ff @(posedge clk) begin
    if (s_valid) frame_q <= frame_d;
  end

`ifdef YIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q       <= '0;
      hop_q        <= '0;
      state_q      <= ST_IDLE;
      wait_first_q <= 1'b0;
      mod_reset_q  <= 1'b1;
      mod_data_q   <= '0;
      tau_q        <= '0;
      voiced_q     <= 1'b0;
      tau_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef YIN_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      if (s_valid) begin
        fill_q <= fill_nx;
        hop_q  <= hop_nx;
      end
      overrun_q   <= trigger && (state_q != ST_IDLE);
      tau_valid_q <= 1'b0;
`ifdef YIN_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          mod_reset_q <= 1'b1;
          if (trigger) begin
            mod_data_q <= frame_d;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mod_reset_q  <= 1'b0;
          wait_first_q <= 1'b1;
`ifdef YIN_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_first_q <= 1'b0;
          if (pick_start) begin
            state_q <= ST_SCAN;
          end
`ifdef YIN_TIMEOUT_EN
          else if (wait_cnt_q == TO_LAST) begin
            tau_q       <= '0;
            voiced_q    <= 1'b0;
            tau_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            mod_reset_q <= 1'b1;
            state_q     <= ST_REPORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_SCAN: begin
          if (pick_done) begin
            tau_q       <= pick_tau;
            voiced_q    <= pick_voiced;
            tau_valid_q <= 1'b1;
            mod_reset_q <= 1'b1;
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign mod_if.mod_reset = mod_reset_q;
  assign mod_if.mod_data  = mod_data_q;
  assign tau_out          = tau_q;
  assign voiced           = voiced_q;
  assign tau_valid        = tau_valid_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != ST_IDLE);
endmodule

// File: doc/yin_frame_scheduler.md
Name: yin_frame_scheduler

Overview:
Sequences the YIN difference-function datapath (modiff_module) over a live sample stream.
- Shifts incoming samples into a frame buffer.
- Every HOP samples, once the buffer is full, snapshots the frame and launches modiff_module via its reset.
- Waits for ready, then scans the d'(tau) results to pick the pitch period tau.
- Sits between the ADC sample stream and the downstream pitch-to-note logic.

Parameters:
DATA_WIDTH, 8, sample width in bits
WINDOW_SIZE_BITS, 8, log2 of the analysis window length
MAX_TAU, 40, number of lags computed by modiff_module
INTERMEDIATE_DATA_WIDTH, 64, width of each d'(tau) result
HOP, 128, samples between successive frame launches (≥1)
MIN_TAU, 2, first lag considered by the picker (1..MAX_TAU-1)
TIMEOUT_CYCLES, 65535, WAIT watchdog limit (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  sample strobe; sample accepted whenever high
s_data  in  DATA_WIDTH  unsigned sample
threshold  in  INTERMEDIATE_DATA_WIDTH  voicing threshold for d'(tau)
mod_reset  out  1  drives modiff_module reset
mod_ready  in  1  modiff_module ready
mod_data  out  FRAME_LEN*DATA_WIDTH  frozen frame; element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
mod_results  in  MAX_TAU*INTERMEDIATE_DATA_WIDTH  flattened d'(k), k at bits [(k+1)*IDW-1 -: IDW]
tau_out  out  TAU_BITS  selected lag
voiced  out  1  1 = some lag fell below threshold
tau_valid  out  1  one-cycle pulse; tau_out/voiced valid
busy  out  1  high in any state other than IDLE
overrun  out  1  one-cycle pulse; trigger dropped because busy

Behaviour:
- Derived constants: FRAME_LEN = (1<<WINDOW_SIZE_BITS)+MAX_TAU; TAU_BITS = $clog2(MAX_TAU).
- Reset: all outputs and state cleared to 0, except mod_reset = 1. FSM enters IDLE; fill_cnt = 0, hop_cnt = 0; frame buffer contents are don't-care.
- Shift buffer: on s_valid, frame[i] <= frame[i+1] and frame[FRAME_LEN-1] <= s_data. Index 0 is the oldest sample. The buffer shifts in every state and is never stalled.
- fill_cnt saturates at FRAME_LEN. hop_cnt increments modulo HOP on s_valid.
- Trigger: s_valid && fill_cnt reaches or equals FRAME_LEN after this sample && hop_cnt == HOP-1. The first trigger occurs at the FRAME_LEN-th sample only if that sample also satisfies the hop condition; otherwise it occurs at the next hop wrap.
- Trigger in IDLE: snapshot frame including the current sample into mod_data; go to LOAD. mod_data is held constant until the next snapshot.
- Trigger in any other state: pulse overrun and drop the frame. This includes the REPORT cycle; no queueing.
- FSM:
  - IDLE: mod_reset = 1.
  - LOAD (1 cycle): mod_reset = 1 → WAIT.
  - WAIT: mod_reset = 0. mod_ready is ignored in the first WAIT cycle (stale-ready guard). Afterwards mod_ready = 1 → SCAN with k = MIN_TAU.
  - SCAN: one lag per cycle.
    - Phase A: find the first k with d'(k) < threshold (unsigned).
    - Phase B: once found, advance while d'(k+1) < d'(k) and k+1 < MAX_TAU; stop at the local minimum.
    - Throughout, track the running argmin (lowest k wins ties).
    - Exit conditions: Phase B done → tau = k, voiced = 1. k passes MAX_TAU-1 without a hit → tau = argmin, voiced = 0.
    - SCAN → REPORT.
  - REPORT (1 cycle): tau_valid = 1; tau_out/voiced registered, and they hold until the next REPORT. mod_reset = 1. → IDLE.
- Latency: trigger → mod_reset fall is 2 cycles; mod_ready → tau_valid is at most MAX_TAU-MIN_TAU+2 cycles.
- mod_ready dropping during SCAN is ignored; mod_results must be stable while mod_ready = 1.
- Reset mid-operation: abort immediately. No tau_valid is produced; mod_reset returns to 1.

Optional Feature:
YIN_TIMEOUT_EN
- Defined: a WAIT cycle counter is active. Reaching TIMEOUT_CYCLES forces REPORT with tau_out = 0 and voiced = 0, and a 1-bit output port timeout pulses with tau_valid.
- Undefined: the counter and the timeout port are absent, and WAIT blocks indefinitely.

Decomposition:
- yin_pkg: state enum (IDLE, LOAD, WAIT, SCAN, REPORT), FRAME_LEN/TAU_BITS helper functions, and the scan-phase enum.
- Sub-module yin_tau_picker: the SCAN-phase lag search. Inputs: start, results, threshold. Outputs: done, tau, voiced. The top keeps the buffer, counters and FSM.

Test Plan:
Use WINDOW_SIZE_BITS=4, MAX_TAU=8 (FRAME_LEN=24), HOP=8, MIN_TAU=1, threshold=50.
1. Reset → mod_reset=1, busy=0, tau_valid=0, overrun=0, tau_out=0.
2. Feed samples 1..24 → no trigger through sample 23; after sample 24, LOAD, then mod_reset=0 two cycles after the trigger; mod_data element 0 = 1 and element 23 = 24.
3. Results {100,90,40,30,35,20,60,70}, pulse mod_ready → tau_out=3, voiced=1, single tau_valid.
4. Results {100,90,80,70,60,55,52,58} → tau_out=6, voiced=0.
5. Hold mod_ready=0 and feed 8 more samples → overrun pulses once, busy stays 1, mod_data unchanged; the next trigger after REPORT launches normally.
6. Assert reset during WAIT → next cycle IDLE, mod_reset=1, no tau_valid; the next trigger needs 24 fresh samples.
